// File: rtl/onewire_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_pkg
//  Description : Shared op encodings, FSM state codes and slot timing (in us)
//                for the 1-Wire bus master.
//  Revision    : 1.0
// ============================================================================
package onewire_pkg;

    localparam logic [1:0] OP_RESET      = 2'b00;
    localparam logic [1:0] OP_WRITE_BYTE = 2'b01;
    localparam logic [1:0] OP_READ_BYTE  = 2'b10;
    localparam logic [1:0] OP_BIT        = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_LOW  = 3'd1;
    localparam logic [2:0] ST_RST_REL  = 3'd2;
    localparam logic [2:0] ST_SLOT_LOW = 3'd3;
    localparam logic [2:0] ST_SLOT_REL = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam logic [9:0] T_RST_LOW    = 10'd480;
    localparam logic [9:0] T_RST_SAMPLE = 10'd550;
    localparam logic [9:0] T_RST_END    = 10'd960;
    localparam logic [9:0] T_LOW1       = 10'd6;
    localparam logic [9:0] T_LOW0       = 10'd60;
    localparam logic [9:0] T_SAMPLE     = 10'd15;
    localparam logic [9:0] T_SLOT       = 10'd70;

endpackage : onewire_pkg
`default_nettype wire

// File: rtl/onewire_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_timebase
//  Description : Microsecond prescaler and 10-bit microsecond counter with a
//                synchronous clear that restarts both.
//  Revision    : 1.0
// ============================================================================
module onewire_timebase #(
    parameter int TICKS_PER_US = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    output logic       us_tick,
    output logic [9:0] us_count
);

    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0] C_PRE_MAX = PW'(TICKS_PER_US - 1);

    logic [PW-1:0] r_prescale;
    logic [9:0]    r_us_count;

    assign us_tick  = (r_prescale == C_PRE_MAX);
    assign us_count = r_us_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= '0;
            r_us_count <= '0;
        end else if (clr) begin
            r_prescale <= '0;
            r_us_count <= '0;
        end else if (us_tick) begin
            r_prescale <= '0;
            r_us_count <= r_us_count + 10'd1;
        end else begin
            r_prescale <= r_prescale + {{(PW-1){1'b0}}, 1'b1};
        end
    end

endmodule : onewire_timebase
`default_nettype wire

// File: rtl/onewire_master.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_master
//  Description : Open-drain 1-Wire bus master issuing bus resets, single bit
//                slots and byte transfers through a command/response handshake.
//  Revision    : 1.0
// ============================================================================
module onewire_master
    import onewire_pkg::*;
#(
    parameter int TICKS_PER_US = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_presence,
    output logic       busy,
    output logic       pad_i,
    output logic       pad_t,
    input  logic       pad_o
);

    logic [2:0] r_state;
    logic [1:0] r_op;
    logic [7:0] r_tx;
    logic [7:0] r_shift;
    logic [2:0] r_left;
    logic       r_pres_smp;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_pad_t;
    logic [7:0] r_rsp_data;
    logic       r_rsp_presence;

    logic       w_us_tick;
    logic [9:0] w_us_count;
    logic       w_accept;
    logic       w_bit_end;
    logic       w_slot_end;
    logic       w_slot_sample;
    logic       w_next_slot;
    logic       w_clr;

    assign cmd_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign busy         = ~cmd_ready;
    assign rsp_valid    = (r_state == ST_DONE);
    assign rsp_data     = r_rsp_data;
    assign rsp_presence = r_rsp_presence;
    assign pad_i        = 1'b0;
    assign pad_t        = r_pad_t;

    assign w_accept   = cmd_valid & cmd_ready;
    // Phase boundaries fire on the tick that carries the counter onto the target.
    assign w_bit_end  = w_us_tick && (w_us_count == ((r_tx[0] ? T_LOW1 : T_LOW0) - 10'd1));
    assign w_slot_end = w_us_tick && (w_us_count == (T_SLOT - 10'd1));
    assign w_slot_sample = w_us_tick && (w_us_count == (T_SAMPLE - 10'd1)) &&
                           ((r_state == ST_SLOT_LOW) || (r_state == ST_SLOT_REL));
    assign w_next_slot = (r_state == ST_SLOT_REL) && w_slot_end && (r_left != 3'd0);
    assign w_clr       = w_accept || w_next_slot;

    onewire_timebase #(
        .TICKS_PER_US (TICKS_PER_US)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .us_tick  (w_us_tick),
        .us_count (w_us_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= pad_o;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_RESET;
            r_tx           <= 8'h00;
            r_shift        <= 8'h00;
            r_left         <= 3'd0;
            r_pres_smp     <= 1'b1;
            r_pad_t        <= 1'b1;
            r_rsp_data     <= 8'h00;
            r_rsp_presence <= 1'b0;
        end else begin
            if (w_slot_sample) begin
                r_shift <= {r_sync2, r_shift[7:1]};
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_tx    <= (cmd_op == OP_READ_BYTE) ? 8'hFF : cmd_data;
                        r_left  <= (cmd_op == OP_BIT) ? 3'd0 : 3'd7;
                        r_shift <= 8'h00;
                        r_pad_t <= 1'b0;
                        r_state <= (cmd_op == OP_RESET) ? ST_RST_LOW : ST_SLOT_LOW;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RST_LOW: begin
                    if (w_us_tick && (w_us_count == (T_RST_LOW - 10'd1))) begin
                        r_pad_t <= 1'b1;
                        r_state <= ST_RST_REL;
                    end
                end
                ST_RST_REL: begin
                    if (w_us_tick && (w_us_count == (T_RST_SAMPLE - 10'd1))) begin
                        r_pres_smp <= r_sync2;
                    end
                    if (w_us_tick && (w_us_count == (T_RST_END - 10'd1))) begin
                        r_rsp_presence <= ~r_pres_smp;
                        r_state        <= ST_DONE;
                    end
                end
                ST_SLOT_LOW: begin
                    if (w_bit_end) begin
                        r_pad_t <= 1'b1;
                        r_state <= ST_SLOT_REL;
                    end
                end
                ST_SLOT_REL: begin
                    if (w_slot_end) begin
                        if (r_left != 3'd0) begin
                            r_left  <= r_left - 3'd1;
                            r_tx    <= {1'b0, r_tx[7:1]};
                            r_pad_t <= 1'b0;
                            r_state <= ST_SLOT_LOW;
                        end else begin
                            // A single BIT slot leaves its sample at the MSB.
                            r_rsp_data <= (r_op == OP_BIT) ? {7'b0, r_shift[7]} : r_shift;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                default: begin
                    r_pad_t <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : onewire_master
`default_nettype wire

// File: tb/tb_onewire_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onewire_master
//  Description : Bench for onewire_master on an open-drain bus with a slave model.
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_onewire_master;
    import onewire_pkg::*;

    localparam int TPU = 4;

    typedef struct {
        logic [7:0] d;
        logic       p;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_presence, busy, pad_i, pad_t, pad_o;
    logic [7:0] rsp_data;
    logic       slave_pull = 1'b0;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   low_run = 0;
    int   low_w[$];
    exp_t exp_q[$];
    int   slave_mode = 0;
    int   slot_idx = 0;
    logic [7:0] rd_pat = 8'h85;

    assign pad_o = (pad_t ? 1'b1 : pad_i) & ~slave_pull;

    onewire_master #(.TICKS_PER_US(TPU)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_presence (rsp_presence),
        .busy         (busy),
        .pad_i        (pad_i),
        .pad_t        (pad_t),
        .pad_o        (pad_o)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // Low-pulse widths of the master drive, in clock cycles.
    always @(negedge clk) begin
        if (rst) low_run = 0;
        else if (!pad_t) low_run++;
        else if (low_run > 0) begin
            low_w.push_back(low_run);
            low_run = 0;
        end
    end

    // Slave: presence pulse 500..620 us after reset start, or read-slot hold 0..30 us.
    always @(negedge pad_t) begin
        if (slave_mode == 1) begin
            repeat (500*TPU) @(negedge clk);
            slave_pull = 1'b1;
            repeat (120*TPU) @(negedge clk);
            slave_pull = 1'b0;
        end else if (slave_mode == 2) begin
            if (rd_pat[slot_idx[2:0]]) begin
                slave_pull = 1'b1;
                repeat (30*TPU) @(negedge clk);
                slave_pull = 1'b0;
            end
            slot_idx++;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.nm, "_data"}, {24'd0, rsp_data}, {24'd0, e.d});
                chk({e.nm, "_presence"}, {31'd0, rsp_presence}, {31'd0, e.p});
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input logic [7:0] exp_d,
                          input logic exp_p, input int exp_len, input string nm, input bit poke);
        int t0;
        int n;
        exp_t e;
        @(negedge clk);
        chk({nm, "_ready_before"}, {31'd0, cmd_ready}, 32'd1);
        e.d = exp_d; e.p = exp_p; e.nm = nm;
        exp_q.push_back(e);
        low_w.delete();
        cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t0 = cyc;
        chk({nm, "_drive_start"}, {31'd0, pad_t}, 32'd0);
        if (poke) begin
            cmd_op = OP_RESET; cmd_valid = 1'b1;
            repeat (10) @(negedge clk);
            chk({nm, "_ready_while_busy"}, {31'd0, cmd_ready}, 32'd0);
            chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
            cmd_valid = 1'b0;
        end
        n = 0;
        while (!rsp_valid && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_length"}, cyc - t0, exp_len);
            chk({nm, "_ready_in_done"}, {31'd0, cmd_ready}, 32'd1);
        end
    endtask

    task automatic chk_widths(input string nm, input int exp_n, input int exp_w[8]);
        chk({nm, "_low_count"}, low_w.size(), exp_n);
        for (int i = 0; i < exp_n && i < low_w.size(); i++) begin
            chk($sformatf("%s_low%0d", nm, i), low_w[i], exp_w[i]);
        end
    endtask

    initial begin
        int w_rst[8];
        int w_3c[8];
        w_rst = '{1920, 0, 0, 0, 0, 0, 0, 0};
        w_3c  = '{240, 240, 24, 24, 24, 24, 240, 240};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pad_t", {31'd0, pad_t}, 32'd1);
        chk("rst_pad_i", {31'd0, pad_i}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
        chk("rst_rsp_presence", {31'd0, rsp_presence}, 32'd0);

        slave_mode = 1;
        do_cmd(OP_RESET, 8'h00, 8'h00, 1'b1, 3840, "reset_present", 1'b0);
        chk_widths("reset_present", 1, w_rst);
        slave_mode = 0;

        do_cmd(OP_WRITE_BYTE, 8'hA5, 8'hA5, 1'b1, 2240, "write_a5", 1'b0);
        do_cmd(OP_RESET, 8'h00, 8'hA5, 1'b0, 3840, "reset_absent", 1'b0);

        do_cmd(OP_WRITE_BYTE, 8'h3C, 8'h3C, 1'b0, 2240, "write_3c", 1'b0);
        chk_widths("write_3c", 8, w_3c);

        slave_mode = 2; slot_idx = 0;
        do_cmd(OP_READ_BYTE, 8'h00, 8'h7A, 1'b0, 2240, "read_byte", 1'b0);
        slave_mode = 0;

        do_cmd(OP_BIT, 8'hFE, 8'h00, 1'b0, 280, "bit0", 1'b0);
        do_cmd(OP_BIT, 8'h01, 8'h01, 1'b0, 280, "bit1_poke", 1'b1);
        repeat (5) @(negedge clk);
        chk("after_bit_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Reset in the fifth slot (280..350 us) of a write of 0x00.
        @(negedge clk);
        cmd_op = OP_WRITE_BYTE; cmd_data = 8'h00; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (1199) @(negedge clk);
        chk("mid_write_pad_low", {31'd0, pad_t}, 32'd0);
        #1 rst = 1'b1;
        #1 chk("rst_async_pad_t", {31'd0, pad_t}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_rsp_data", {24'd0, rsp_data}, 32'h00);

        slave_mode = 1;
        do_cmd(OP_RESET, 8'h00, 8'h00, 1'b1, 3840, "reset_after_rst", 1'b0);
        slave_mode = 0;

        repeat (5) @(negedge clk);
        chk("pending_responses", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_onewire_master
`default_nettype wire
